alkcseq: RTL and testbench

ALK carry sequencer for the DC615 ALK (ALU Control) chip. It holds the ALKC microarchitectural carry flag and runs the divide-step state machine that produces `carry_invert_h`. Both outputs feed the ALK carry-input multiplexer directly downstream. It captures the ALU carry returned from the data slices each microcycle and tracks progress through a 32-step non-restoring divide, including double-precision steps.

---
 rtl/alk_pkg.sv | 23 ++
 rtl/alkcseq_if.sv | 32 +++
 rtl/alkcdivfsm.sv | 81 ++++++++
 rtl/alkcseq.sv | 70 +++++++
 tb/tb_alkcseq.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/alk_pkg.sv
// Shared types and constants for the ALK carry sequencer.
//   alkc_state_t : divide sequencer states
//   alkc_cmd_t   : decoded, enable-gated, active-high microcycle commands
package alk_pkg;

  localparam int unsigned ALK_DIV_STEPS = 32;
  localparam int unsigned ALK_CNT_W     = $clog2(ALK_DIV_STEPS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIV    = 2'd1,
    DBL_HI = 2'd2
  } alkc_state_t;

  typedef struct packed {
    logic divinit;
    logic divstep;
    logic divdbl;
    logic alkc_load;
    logic alkc_clear;
  } alkc_cmd_t;

endpackage

// File: rtl/alkcseq_if.sv
// Microcycle bus between the ALPCTL/ROT decode, ALU slices and the carry sequencer.
//   master : decode/ALU side, drives enable, decodes (active-low) and ALU carry
//   slave  : sequencer side, returns ALKC flag, carry invert, step count, last-step
interface alkcseq_if import alk_pkg::*; #(
  parameter int unsigned CNT_W = ALK_CNT_W
);

  logic             cyc_en_h;
  logic             alpctl_divinit_l;
  logic             alpctl_divstep_l;
  logic             alpctl_divdbl_l;
  logic             alkc_load_l;
  logic             alkc_clear_l;
  logic             alu_cout_h;
  logic             alkc_flag_h;
  logic             carry_invert_h;
  logic [CNT_W-1:0] div_count_h;
  logic             div_last_h;

  modport master (
    output cyc_en_h, alpctl_divinit_l, alpctl_divstep_l, alpctl_divdbl_l,
           alkc_load_l, alkc_clear_l, alu_cout_h,
    input  alkc_flag_h, carry_invert_h, div_count_h, div_last_h
  );

  modport slave (
    input  cyc_en_h, alpctl_divinit_l, alpctl_divstep_l, alpctl_divdbl_l,
           alkc_load_l, alkc_clear_l, alu_cout_h,
    output alkc_flag_h, carry_invert_h, div_count_h, div_last_h
  );

endinterface

// File: rtl/alkcdivfsm.sv
// Divide-step sequencer: state register, step counter and carry-invert register.
//   clk_h, reset_l  : clock, async active-low reset
//   en              : microcycle advance
//   divinit/divstep/divdbl : active-high, already enable-gated decodes
//   alu_cout_h      : ALU carry of the current cycle
//   state, count, carry_invert : registered sequencer state
//   dbl_capture_c   : this cycle is a low-half step whose carry feeds ALKC
module alkcdivfsm import alk_pkg::*; #(
  parameter  int unsigned DIV_STEPS = ALK_DIV_STEPS,
  localparam int unsigned CNT_W     = $clog2(DIV_STEPS)
) (
  input  logic             clk_h,
  input  logic             reset_l,
  input  logic             en,
  input  logic             divinit,
  input  logic             divstep,
  input  logic             divdbl,
  input  logic             alu_cout_h,
  output alkc_state_t      state,
  output logic [CNT_W-1:0] count,
  output logic             carry_invert,
  output logic             dbl_capture_c
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_STEPS - 1);

  alkc_state_t      state_d;
  logic [CNT_W-1:0] count_d;
  logic             carry_invert_d;

  // Next-state decode; divinit beats everything, divdbl beats divstep in DIV.
  always_comb begin
    state_d        = state;
    count_d        = count;
    carry_invert_d = carry_invert;
    dbl_capture_c  = 1'b0;
    if (en) begin
      if (divinit) begin
        state_d        = DIV;
        count_d        = '0;
        carry_invert_d = 1'b1;
      end else begin
        case (state)
          IDLE: carry_invert_d = 1'b0;
          DIV: begin
            if (divdbl) begin
              state_d       = DBL_HI;
              dbl_capture_c = 1'b1;
            end else if (divstep) begin
              carry_invert_d = alu_cout_h;
              count_d        = count + CNT_W'(1);
              state_d        = (count == LAST_CNT) ? IDLE : DIV;
            end
          end
          DBL_HI: begin
            if (divstep) begin
              carry_invert_d = alu_cout_h;
              count_d        = count + CNT_W'(1);
              state_d        = (count == LAST_CNT) ? IDLE : DIV;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // Sequencer registers.
  always_ff @(posedge clk_h or negedge reset_l) begin
    if (!reset_l) begin
      state        <= IDLE;
      count        <= '0;
      carry_invert <= 1'b0;
    end else begin
      state        <= state_d;
      count        <= count_d;
      carry_invert <= carry_invert_d;
    end
  end

endmodule

// File: rtl/alkcseq.sv
// ALK carry sequencer: ALKC carry flag and divide-step carry-invert control.
//   clk_h   : microcycle clock
//   reset_l : async active-low reset
//   bus     : slave side of alkcseq_if (decodes, ALU carry in; flag, invert,
//             step count and last-step indication out)
module alkcseq import alk_pkg::*; #(
  parameter int unsigned DIV_STEPS = ALK_DIV_STEPS
) (
  input  logic       clk_h,
  input  logic       reset_l,
  alkcseq_if.slave   bus
);

  localparam int unsigned      CNT_W    = $clog2(DIV_STEPS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_STEPS - 1);

  alkc_cmd_t        cmd;
  alkc_state_t      state;
  logic [CNT_W-1:0] count;
  logic             carry_invert;
  logic             dbl_capture_c;
  logic             alkc_flag;

  // Active-high decodes, forced inactive on stalled cycles.
  always_comb begin
    cmd = '0;
    if (bus.cyc_en_h) begin
      cmd.divinit    = ~bus.alpctl_divinit_l;
      cmd.divstep    = ~bus.alpctl_divstep_l;
      cmd.divdbl     = ~bus.alpctl_divdbl_l;
      cmd.alkc_load  = ~bus.alkc_load_l;
      cmd.alkc_clear = ~bus.alkc_clear_l;
    end
  end

  alkcdivfsm #(
    .DIV_STEPS (DIV_STEPS)
  ) u_divfsm (
    .clk_h         (clk_h),
    .reset_l       (reset_l),
    .en            (bus.cyc_en_h),
    .divinit       (cmd.divinit),
    .divstep       (cmd.divstep),
    .divdbl        (cmd.divdbl),
    .alu_cout_h    (bus.alu_cout_h),
    .state         (state),
    .count         (count),
    .carry_invert  (carry_invert),
    .dbl_capture_c (dbl_capture_c)
  );

  // ALKC flag: clear beats the low-half carry capture, which beats a plain load.
  always_ff @(posedge clk_h or negedge reset_l) begin
    if (!reset_l) begin
      alkc_flag <= 1'b0;
    end else if (cmd.alkc_clear) begin
      alkc_flag <= 1'b0;
    end else if (dbl_capture_c) begin
      alkc_flag <= bus.alu_cout_h;
    end else if (cmd.alkc_load) begin
      alkc_flag <= bus.alu_cout_h;
    end
  end

  assign bus.alkc_flag_h    = alkc_flag;
  assign bus.carry_invert_h = carry_invert;
  assign bus.div_count_h    = count;
  assign bus.div_last_h     = (state != IDLE) && (count == LAST_CNT);

endmodule

// File: tb/tb_alkcseq.sv
// Scoreboard bench for alkcseq: the driver pushes hand-derived expected outputs
// for each cycle it drives; the monitor pops and compares after every rising edge.
module tb_alkcseq;
  import alk_pkg::*;

  logic clk_h   = 1'b0;
  logic reset_l = 1'b0;

  alkcseq_if bus ();

  alkcseq dut (
    .clk_h   (clk_h),
    .reset_l (reset_l),
    .bus     (bus)
  );

  always #5 clk_h = ~clk_h;

  typedef struct {
    string      name;
    logic       alkc;
    logic       ci;
    logic [4:0] cnt;
    logic       last;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input string fld, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s.%s: got %0d, expected %0d", name, fld, act, req);
    end
  endtask

  // Monitor: one expected entry per driven cycle, compared after the edge.
  always begin
    @(posedge clk_h);
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk(e.name, "alkc_flag",    int'(bus.alkc_flag_h),    int'(e.alkc));
      chk(e.name, "carry_invert", int'(bus.carry_invert_h), int'(e.ci));
      chk(e.name, "div_count",    int'(bus.div_count_h),    int'(e.cnt));
      chk(e.name, "div_last",     int'(bus.div_last_h),     int'(e.last));
    end
  end

  task automatic drive(input bit en, input bit init, input bit step, input bit dbl,
                       input bit load, input bit clr, input bit cout);
    bus.cyc_en_h         = en;
    bus.alpctl_divinit_l = ~init;
    bus.alpctl_divstep_l = ~step;
    bus.alpctl_divdbl_l  = ~dbl;
    bus.alkc_load_l      = ~load;
    bus.alkc_clear_l     = ~clr;
    bus.alu_cout_h       = cout;
  endtask

  task automatic push(input string name, input bit ea, input bit ec,
                      input logic [4:0] ecnt, input bit el);
    exp_t x;
    x.name = name; x.alkc = ea; x.ci = ec; x.cnt = ecnt; x.last = el;
    q.push_back(x);
  endtask

  // One microcycle: stimulus (active-high) followed by expected post-edge outputs.
  task automatic cyc(input bit en, input bit init, input bit step, input bit dbl,
                     input bit load, input bit clr, input bit cout,
                     input bit ea, input bit ec, input logic [4:0] ecnt, input bit el,
                     input string name);
    @(negedge clk_h);
    drive(en, init, step, dbl, load, clr, cout);
    push(name, ea, ec, ecnt, el);
  endtask

  // Random decodes and carry; enable given by caller.
  task automatic cyc_rand(input bit en, input bit ea, input bit ec,
                          input logic [4:0] ecnt, input bit el, input string name);
    @(negedge clk_h);
    drive(en, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
          1'($urandom), 1'($urandom));
    push(name, ea, ec, ecnt, el);
  endtask

  // Reset pulse that never spans a rising edge: only an async reset can act.
  task automatic areset_pulse(input string name);
    @(negedge clk_h);
    drive(0, 0, 0, 0, 0, 0, 0);
    reset_l = 1'b0;
    #2;
    reset_l = 1'b1;
    push(name, 0, 0, 5'd0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    // Reset held with random inputs.
    for (int i = 0; i < 4; i++) cyc_rand(1'($urandom), 0, 0, 5'd0, 0, "rst_hold");
    @(negedge clk_h);
    drive(0, 0, 0, 0, 0, 0, 0);
    reset_l = 1'b1;

    // Full divide, carry alternating 1,0.
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 1, 5'd0, 0, "div1_init");
    for (int i = 0; i < 32; i++)
      cyc(1, 0, 1, 0, 0, 0, (i % 2 == 0), 0, (i % 2 == 0), 5'((i + 1) % 32), (i == 30),
          "div1_step");
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 0, "div1_idle");

    // Double-precision steps.
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 1, 5'd0, 0, "dbl_init");
    for (int i = 0; i < 5; i++)
      cyc(1, 0, 1, 0, 0, 0, 1, 0, 1, 5'(i + 1), 0, "dbl_pre");
    cyc(1, 0, 0, 1, 0, 0, 1, 1, 1, 5'd5, 0, "dbl_capture");
    cyc(1, 0, 0, 1, 0, 0, 0, 1, 1, 5'd5, 0, "dbl_in_hi");
    cyc(1, 0, 1, 0, 0, 0, 0, 1, 0, 5'd6, 0, "dbl_step");
    cyc(1, 0, 0, 1, 0, 0, 0, 0, 0, 5'd6, 0, "dbl_again");
    cyc(1, 0, 1, 0, 0, 0, 1, 0, 1, 5'd7, 0, "dbl_step2");
    cyc(1, 0, 1, 1, 0, 0, 1, 1, 1, 5'd7, 0, "dbl_over_step");
    cyc(1, 0, 1, 0, 0, 0, 0, 1, 0, 5'd8, 0, "dbl_step3");

    // ALKC priority.
    cyc(1, 0, 0, 0, 1, 1, 1, 0, 0, 5'd8, 0, "clr_over_load");
    cyc(1, 0, 0, 0, 1, 0, 1, 1, 0, 5'd8, 0, "load");
    cyc(1, 0, 0, 1, 0, 1, 1, 0, 0, 5'd8, 0, "clr_over_dbl");
    cyc(1, 0, 1, 0, 0, 0, 1, 0, 1, 5'd9, 0, "pri_step");

    // Restart at count 20 leaves ALKC alone.
    cyc(1, 0, 0, 0, 1, 0, 1, 1, 1, 5'd9, 0, "rs_load");
    cyc(1, 1, 0, 0, 0, 0, 0, 1, 1, 5'd0, 0, "rs_init");
    for (int i = 0; i < 20; i++)
      cyc(1, 0, 1, 0, 0, 0, 0, 1, 0, 5'(i + 1), 0, "rs_step");
    cyc(1, 1, 0, 0, 0, 0, 0, 1, 1, 5'd0, 0, "rs_restart");

    // Reset mid-divide at count 17.
    for (int i = 0; i < 17; i++)
      cyc(1, 0, 1, 0, 0, 0, 1, 1, 1, 5'(i + 1), 0, "mr_step");
    areset_pulse("mr_reset");
    cyc(1, 0, 1, 0, 0, 0, 1, 0, 0, 5'd0, 0, "mr_idle_step");

    // Stall mid-divide, then finish with a final carry of 1.
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 1, 5'd0, 0, "st_init");
    for (int i = 0; i < 10; i++)
      cyc(1, 0, 1, 0, 0, 0, (i % 2 == 1), 0, (i % 2 == 1), 5'(i + 1), 0, "st_pre");
    for (int i = 0; i < 10; i++) cyc_rand(0, 0, 1, 5'd10, 0, "st_stall");
    for (int i = 10; i < 32; i++)
      cyc(1, 0, 1, 0, 0, 0, (i % 2 == 1), 0, (i % 2 == 1), 5'((i + 1) % 32), (i == 30),
          "st_post");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd0, 0, "st_hold_ci");
    cyc(1, 0, 0, 1, 0, 0, 1, 0, 0, 5'd0, 0, "st_idle_clear");

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk_h);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
